// File: rtl/pe_psum_accumulator.sv
// Saturating accumulator for PE adder-tree partial sums. Sums a programmed
// number of signed terms and hands the result downstream over valid/ready.
module pe_psum_accumulator #(
    parameter int IN_W  = 21,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [CNT_W-1:0]        i_len,
    input  logic                    i_psum_valid,
    input  logic signed [IN_W-1:0]  i_psum,
    output logic                    o_busy,
    output logic                    o_acc_valid,
    input  logic                    i_acc_ready,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_sat
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;

    logic signed [ACC_W:0]   sum_wide;
    logic                    ovf;
    logic signed [ACC_W-1:0] sum_sat;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q}
                 + {{(ACC_W+1-IN_W){i_psum[IN_W-1]}}, i_psum};
        ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (!ovf)
            sum_sat = sum_wide[ACC_W-1:0];
        else if (sum_wide[ACC_W])
            sum_sat = ACC_MIN;
        else
            sum_sat = ACC_MAX;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (i_len != '0) begin
                        cnt_d   = i_len;
                        state_d = S_ACC;
                    end else begin
                        res_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACC: begin
                if (i_psum_valid) begin
                    acc_d = sum_sat;
                    sat_d = sat_q | ovf;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = sum_sat;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (i_acc_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_acc_valid = valid_q;
    assign o_acc       = res_q;
    assign o_sat       = sat_q;

endmodule
